// File: rtl/dump_pkg.sv
// Shared state encoding and defaults for the capture-buffer dump controller.
// Optional DUMP_HEADER_EN adds the HDR state that sends a 0xA5 preamble byte.
package dump_pkg;

    localparam int unsigned DEF_ENTRIES = 384;
    localparam int unsigned DEF_LOG2    = 9;
    localparam logic [7:0]  HDR_BYTE    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        LATCH   = 3'd2,
        XMIT    = 3'd3,
        WAIT_TX = 3'd4
`ifdef DUMP_HEADER_EN
        ,
        HDR     = 3'd5
`endif
    } dump_state_t;

endpackage

// File: rtl/wrap_cntr.sv
// Loadable address counter that wraps from ENTRIES-1 back to 0, so it never
// addresses past the end of a non-power-of-two sample RAM.
module wrap_cntr
    import dump_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    parameter int unsigned LOG2    = DEF_LOG2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [LOG2-1:0] din,
    output logic [LOG2-1:0] q
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (inc) begin
            q <= (q == LAST) ? '0 : q + LOG2'(1);
        end
    end

endmodule

// File: rtl/dump_ctrl.sv
// Reads the circular capture buffer out oldest-first and feeds it to the UART
// one byte at a time. Define DUMP_HEADER_EN to prefix each dump with 0xA5.
module dump_ctrl
    import dump_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    parameter int unsigned LOG2    = DEF_LOG2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump,
    input  logic            capture_done,
    input  logic [LOG2-1:0] waddr,
    output logic            ren,
    output logic [LOG2-1:0] raddr,
    input  logic [7:0]      rdata,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    output logic            busy,
    output logic            dump_done
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    dump_state_t     state;
    logic [LOG2-1:0] cnt;
    logic            start_c;
    logic            adv_c;

    // Start address is captured only on acceptance; later waddr moves are ignored.
    assign start_c = (state == IDLE) && dump && capture_done;
    assign adv_c   = (state == WAIT_TX) && tx_done && (cnt != LAST);

    wrap_cntr #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_raddr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_c),
        .inc   (adv_c),
        .din   (waddr),
        .q     (raddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_data   <= '0;
            ren       <= 1'b0;
            trmt      <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            ren       <= 1'b0;
            trmt      <= 1'b0;
            dump_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_c) begin
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef DUMP_HEADER_EN
                        tx_data <= HDR_BYTE;
                        trmt    <= 1'b1;
                        state   <= HDR;
`else
                        ren   <= 1'b1;
                        state <= RD;
`endif
                    end
                end
`ifdef DUMP_HEADER_EN
                // tx_done during the strobe cycle is not a completion.
                HDR: begin
                    if (tx_done && !trmt) begin
                        ren   <= 1'b1;
                        state <= RD;
                    end
                end
`endif
                RD: begin
                    state <= LATCH;
                end
                LATCH: begin
                    tx_data <= rdata;
                    trmt    <= 1'b1;
                    state   <= XMIT;
                end
                XMIT: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (cnt == LAST) begin
                            dump_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cnt   <= cnt + LOG2'(1);
                            ren   <= 1'b1;
                            state <= RD;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dump_ctrl.sv
// Scoreboard bench for dump_ctrl: expected addresses/bytes are queued per dump
// from a circular-buffer model; monitor, RAM and UART models run independently.
module tb_dump_ctrl;

    localparam int unsigned ENTRIES = 384;
    localparam int unsigned LOG2    = 9;
`ifdef DUMP_HEADER_EN
    localparam int unsigned NHDR    = 1;
`else
    localparam int unsigned NHDR    = 0;
`endif
    localparam int DUMP_BUDGET = int'(ENTRIES) * 20 + 200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dump = 1'b0;
    logic            capture_done = 1'b1;
    logic            tx_done = 1'b0;
    logic [LOG2-1:0] waddr = '0;
    logic [7:0]      rdata = '0;
    logic            ren, trmt, busy, dump_done;
    logic [LOG2-1:0] raddr;
    logic [7:0]      tx_data;

    int checks = 0;
    int failures = 0;
    logic [LOG2-1:0] exp_addr_q[$];
    logic [7:0]      exp_data_q[$];
    int byte_cnt = 0;
    int done_cnt = 0;
    int ren_cnt = 0;
    bit active = 1'b0;
    bit in_reset_test = 1'b0;
    bit spurious = 1'b0;
    int tx_delay = 10;

    dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dump         (dump),
        .capture_done (capture_done),
        .waddr        (waddr),
        .ren          (ren),
        .raddr        (raddr),
        .rdata        (rdata),
        .tx_data      (tx_data),
        .trmt         (trmt),
        .tx_done      (tx_done),
        .busy         (busy),
        .dump_done    (dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents ren, trmt or dump_done.
    bit prev_tx_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dump_done) begin
                done_cnt++;
                check("dump_done_follows_tx_done", longint'(prev_tx_done), 1);
                check("dump_done_bytes_left", exp_data_q.size(), 0);
                active = 1'b0;
            end
            if (ren) begin
                ren_cnt++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ren: raddr=%0d with no read expected", raddr);
                end else begin
                    logic [LOG2-1:0] ea;
                    ea = exp_addr_q.pop_front();
                    if (raddr != ea) begin
                        failures++;
                        $display("FAIL raddr: got %0d expected %0d", raddr, ea);
                    end
                end
            end
            if (trmt) begin
                byte_cnt++;
                checks++;
                if (exp_data_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_trmt: tx_data=%0h with no byte expected", tx_data);
                end else begin
                    logic [7:0] ed;
                    ed = exp_data_q.pop_front();
                    if (tx_data != ed) begin
                        failures++;
                        $display("FAIL tx_data: got %0h expected %0h (byte %0d)", tx_data, ed, byte_cnt);
                    end
                end
            end
            check("busy", longint'(busy), longint'(active));
        end
        prev_tx_done = tx_done;
    end

    // RAM model: data = low address byte, one cycle after ren; noise otherwise.
    initial begin : ram_model
        logic [LOG2-1:0] a;
        bit pend;
        forever begin
            @(negedge clk);
            pend = ren;
            a    = raddr;
            @(posedge clk);
            #1;
            rdata = pend ? a[7:0] : 8'($urandom);
        end
    end

    // UART model: answers each trmt with tx_done after a delay, checking hold.
    initial begin : uart_model
        logic [7:0] held;
        int d;
        bit abort;
        forever begin
            @(negedge clk);
            if (rst_n && trmt && !in_reset_test) begin
                held  = tx_data;
                d     = (tx_delay == 0) ? int'($urandom_range(12, 2)) : tx_delay;
                abort = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (in_reset_test || !rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    check("tx_data_stable", longint'(tx_data), longint'(held));
                end
                if (!abort) begin
                    @(posedge clk); #1 tx_done = 1'b1;
                    @(posedge clk); #1 tx_done = 1'b0;
                    if (spurious && ($urandom_range(1, 0) == 1)) begin
                        @(posedge clk); #1 tx_done = 1'b1;
                        @(posedge clk); #1 tx_done = 1'b0;
                    end
                end
            end
        end
    end

    task automatic start_dump(input int w);
        for (int i = 0; i < int'(NHDR); i++) exp_data_q.push_back(8'hA5);
        for (int i = 0; i < int'(ENTRIES); i++) begin
            int a;
            a = (w + i) % int'(ENTRIES);
            exp_addr_q.push_back(LOG2'(a));
            exp_data_q.push_back(8'(a));
        end
        byte_cnt = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        waddr = LOG2'(w);
        dump  = 1'b1;
        @(posedge clk); #1;
        dump   = 1'b0;
        active = 1'b1;
    endtask

    task automatic wait_bytes(input string name, input int n);
        int k;
        k = 0;
        while (byte_cnt < n && k < DUMP_BUDGET) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (byte_cnt < n) begin
            failures++;
            $display("FAIL %s_byte_timeout: got %0d bytes expected %0d", name, byte_cnt, n);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < DUMP_BUDGET) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s_timeout: got no dump_done in %0d cycles expected one", name, k);
        end
        repeat (40) @(posedge clk);
        check({name, "_bytes"}, byte_cnt, ENTRIES + NHDR);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_reads_left"}, exp_addr_q.size(), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        active = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0, b0, w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ren", longint'(ren), 0);
        check("rst_trmt", longint'(trmt), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_dump_done", longint'(dump_done), 0);
        check("rst_raddr", longint'(raddr), 0);
        check("rst_tx_data", longint'(tx_data), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Dump without capture_done must be ignored.
        r0 = ren_cnt;
        b0 = byte_cnt;
        @(posedge clk); #1;
        capture_done = 1'b0;
        waddr = LOG2'(7);
        dump  = 1'b1;
        @(posedge clk); #1 dump = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("nocap_busy", longint'(busy), 0);
        check("nocap_ren_count", ren_cnt, r0);
        check("nocap_trmt_count", byte_cnt, b0);
        capture_done = 1'b1;

        // Basic dump from address 5 with fixed UART latency.
        tx_delay = 10;
        start_dump(5);
        wait_done("dump_w5");

        // Oldest sample at the last entry: sequence wraps immediately.
        tx_delay = 0;
        spurious = 1'b1;
        start_dump(int'(ENTRIES) - 1);
        wait_done("dump_wlast");

        // Re-dump, waddr move and capture_done fall partway through are ignored.
        w = int'($urandom_range(ENTRIES - 1, 0));
        start_dump(w);
        wait_bytes("redump", 100);
        @(posedge clk); #1;
        dump  = 1'b1;
        waddr = LOG2'($urandom_range(ENTRIES - 1, 0));
        capture_done = 1'b0;
        @(posedge clk); #1 dump = 1'b0;
        wait_done("dump_redump");
        capture_done = 1'b1;

        // Reset while waiting on byte 50 aborts the dump for good.
        tx_delay = 10;
        spurious = 1'b0;
        start_dump(100);
        wait_bytes("reset", 50);
        repeat (3) @(posedge clk);
        #2;
        in_reset_test = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_ren", longint'(ren), 0);
        check("midrst_trmt", longint'(trmt), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_dump_done", longint'(dump_done), 0);
        check("midrst_raddr", longint'(raddr), 0);
        check("midrst_tx_data", longint'(tx_data), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        active = 1'b0;
        r0 = ren_cnt;
        b0 = byte_cnt;
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        in_reset_test = 1'b0;
        repeat (60) @(posedge clk);
        check("postrst_trmt_count", byte_cnt, b0);
        check("postrst_ren_count", ren_cnt, r0);
        check("postrst_done_count", done_cnt, 0);

        // Fresh dump after the abort starts cleanly.
        tx_delay = 0;
        start_dump(0);
        wait_done("dump_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, sample RAM depth; 12288 is used on DE-0.
REQ-002 Parameter LOG2, default 9, address width; 2^LOG2 >= ENTRIES.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active low.
REQ-005 dump  input  1  one-cycle request to read the capture buffer out.
REQ-006 capture_done  input  1  capture complete, from cmd_cfg; a dump is accepted only while this is high.
REQ-007 waddr  input  LOG2  capture write pointer, which is the address of the oldest sample.
REQ-008 ren  output  1  RAM read enable.
REQ-009 raddr  output  LOG2  RAM read address.
REQ-010 rdata  input  8  RAM read data, valid the cycle after ren.
REQ-011 tx_data  output  8  byte to UART transmitter.
REQ-012 trmt  output  1  one-cycle strobe to start UART transmission.
REQ-013 tx_done  input  1  UART finished the current byte.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 dump_done  output  1  one-cycle pulse when the last byte completes.

Function
REQ-016 FSM states are IDLE, RD, LATCH, XMIT, WAIT_TX and HDR; HDR exists only with DUMP_HEADER_EN.
- REQ-017 IDLE: dump && capture_done loads raddr<=waddr and cnt<=0, then goes to HDR (macro defined) or RD.
- Otherwise dump is ignored.
REQ-018 RD: ren=1 for one cycle, then LATCH.
REQ-019 LATCH: tx_data<=rdata (1-cycle RAM latency), then XMIT.
REQ-020 XMIT: trmt=1 for exactly one cycle, then WAIT_TX.
- REQ-021 WAIT_TX: waits for tx_done.
- If cnt==ENTRIES-1, it pulses dump_done and goes to IDLE.
- Otherwise it advances raddr, increments cnt and returns to RD.
REQ-022 raddr advance wraps ENTRIES-1 -> 0 and never reaches addresses >= ENTRIES.
REQ-023 cnt is LOG2 bits wide; exactly ENTRIES bytes are sent per dump, oldest first.
REQ-024 tx_data is held stable from trmt until tx_done.
REQ-025 dump asserted while busy is ignored; it neither restarts nor queues.
REQ-026 tx_done seen in any state other than WAIT_TX is ignored.
REQ-027 A capture_done fall mid-dump does not abort the dump.
REQ-028 A waddr change mid-dump has no effect, because the start address is latched in IDLE only.
REQ-029 waddr==ENTRIES-1 at start gives the sequence ENTRIES-1, 0, 1, ... ENTRIES-2.

Reset
REQ-030 On rst_n low, asynchronously:
- state=IDLE;
- raddr=0, cnt=0, tx_data=0;
- ren, trmt, busy and dump_done are all 0.
REQ-031 Reset mid-dump aborts the dump; no trmt or dump_done is emitted after release until a new dump arrives.

Configuration
REQ-032 Macro DUMP_HEADER_EN:
- When defined, HDR loads tx_data=8'hA5, pulses trmt and waits for tx_done before entering RD, so a dump totals ENTRIES+1 bytes.
- When undefined, HDR is absent and IDLE goes straight to RD.

Structure
REQ-033 Package dump_pkg holds:
- the state enum typedef (dump_state_t);
- HDR_BYTE (8'hA5);
- the default ENTRIES and LOG2 constants.
REQ-034 One sub-module, wrap_cntr, provides the loadable wrap-at-ENTRIES-1 address counter with load and inc inputs; it is instantiated for raddr.

Verification
REQ-035 ENTRIES=384, waddr=5, capture_done=1, dump pulse, tx_done 10 cycles after each trmt:
- response: 384 trmt strobes;
- addresses 5..383 then 0..4;
- dump_done is high for 1 cycle after the 384th tx_done.
REQ-036 RAM model rdata=addr[7:0]:
- each tx_data equals the low byte of raddr issued 2 cycles earlier;
- tx_data is stable until tx_done.
REQ-037 dump with capture_done=0:
- busy stays 0;
- no ren or trmt is issued.
REQ-038 A second dump pulse at byte 100:
- the byte count is unchanged at 384;
- exactly one dump_done is produced.
REQ-039 Assert rst_n low during WAIT_TX of byte 50:
- all outputs go to 0 and state to IDLE immediately;
- no trmt follows until a new dump arrives.
REQ-040 DUMP_HEADER_EN defined, waddr=0:
- the first tx_data is 8'hA5, followed by addresses 0..383;
- 385 trmt strobes in total.
